// File: rtl/instr_decode_stream.sv
// Splits dual-slot fetch words into condition-checked ALU/MEM/MOVE beats; MOVE-imm pulls its immediate from the next slot.
// First beat one clock after accept, then 1 beat/clk; out_valid&~out_ready freezes the output register and stalls fetch.
module instr_decode_stream #(
  parameter int WIDTH       = 32,
  parameter int OPCODE      = 4,
  parameter int REGS_CODING = 3,
  parameter int FLAGS       = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       long_instr,
  input  logic                   start_hi,
  input  logic [FLAGS-1:0]       flags,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   alu_en,
  output logic [OPCODE-1:0]      opcode,
  output logic                   mem_en,
  output logic                   wren,
  output logic                   move_en,
  output logic [1:0]             mode,
  output logic [WIDTH/2-1:0]     immediate,
  output logic [REGS_CODING-1:0] op1,
  output logic [REGS_CODING-1:0] op2,
  output logic                   suffix,
  output logic                   illegal
);

  localparam int IW     = WIDTH / 2;
  localparam int P_CLS  = IW - 2;
  localparam int P_FUNC = P_CLS - OPCODE;
  localparam int P_OP1  = P_FUNC - REGS_CODING;
  localparam int P_OP2  = P_OP1 - REGS_CODING;
  localparam int P_COND = P_OP2 - 3;
  localparam int P_SUF  = P_COND - 1;

  localparam int F_CARRY    = 0;
  localparam int F_SIGN     = 1;
  localparam int F_OVERFLOW = 2;
  localparam int F_ZERO     = 3;

  typedef struct packed {
    logic                   alu_en;
    logic [OPCODE-1:0]      opcode;
    logic                   mem_en;
    logic                   wren;
    logic                   move_en;
    logic [1:0]             mode;
    logic [IW-1:0]          immediate;
    logic [REGS_CODING-1:0] op1;
    logic [REGS_CODING-1:0] op2;
    logic                   suffix;
    logic                   illegal;
  } beat_t;

  typedef enum logic [1:0] {S_IDLE, S_LO, S_HI, S_IMMW} state_t;

  state_t        r_state;
  logic [WIDTH-1:0] r_word;
  logic [IW-1:0] r_hold;
  logic          r_out_valid;
  beat_t         r_beat;

  logic          w_adv;
  logic          w_in_ready;
  logic [IW-1:0] w_slot;
  logic [IW-1:0] w_imm;
  logic [2:0]    w_cond;
  logic          w_pass;
  logic          w_mi;
  beat_t         w_beat;

  assign w_adv = ~r_out_valid | out_ready;

  always_comb begin
    w_in_ready = 1'b0;
    case (r_state)
      S_IDLE:         w_in_ready = 1'b1;
      S_HI, S_IMMW:   w_in_ready = w_adv;
      default:        w_in_ready = 1'b0;
    endcase
    if (flush) w_in_ready = 1'b0;
  end

  // The slot under decode and where its immediate would come from, per state.
  always_comb begin
    w_slot = r_word[IW-1:0];
    w_imm  = r_word[WIDTH-1:IW];
    case (r_state)
      S_HI: begin
        w_slot = r_word[WIDTH-1:IW];
        w_imm  = long_instr[IW-1:0];
      end
      S_IMMW: begin
        w_slot = r_hold;
        w_imm  = long_instr[IW-1:0];
      end
      default: begin
        w_slot = r_word[IW-1:0];
        w_imm  = r_word[WIDTH-1:IW];
      end
    endcase
  end

  always_comb begin
    w_cond = w_slot[P_COND +: 3];
    case (w_cond)
      3'd0:    w_pass = 1'b1;
      3'd1:    w_pass = flags[F_ZERO];
      3'd2:    w_pass = ~flags[F_ZERO];
      3'd3:    w_pass = flags[F_CARRY];
      3'd4:    w_pass = ~flags[F_CARRY];
      3'd5:    w_pass = flags[F_SIGN];
      3'd6:    w_pass = flags[F_OVERFLOW];
      default: w_pass = 1'b0;
    endcase
  end

  assign w_mi = (w_slot[P_CLS +: 2] == 2'b10) && !w_slot[P_FUNC + 1];

  always_comb begin
    w_beat        = '0;
    w_beat.op1    = w_slot[P_OP1 +: REGS_CODING];
    w_beat.op2    = w_slot[P_OP2 +: REGS_CODING];
    w_beat.suffix = w_slot[P_SUF];
    case (w_slot[P_CLS +: 2])
      2'b00: begin
        w_beat.alu_en = 1'b1;
        w_beat.opcode = w_slot[P_FUNC +: OPCODE];
      end
      2'b01: begin
        w_beat.mem_en = 1'b1;
        w_beat.wren   = w_slot[P_FUNC];
      end
      2'b10: begin
        w_beat.move_en   = 1'b1;
        w_beat.mode      = w_slot[P_FUNC +: 2];
        w_beat.immediate = w_slot[P_FUNC + 1] ? '0 : w_imm;
      end
      default: w_beat.illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_word      <= '0;
      r_hold      <= '0;
      r_out_valid <= 1'b0;
      r_beat      <= '0;
    end else if (flush) begin
      r_state     <= S_IDLE;
      r_out_valid <= 1'b0;
    end else begin
      if (w_adv) r_out_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_word  <= long_instr;
            r_state <= start_hi ? S_HI : S_LO;
          end
        end
        S_LO: begin
          if (w_adv) begin
            if (w_pass) begin
              r_out_valid <= 1'b1;
              r_beat      <= w_beat;
            end
            r_state <= w_mi ? S_IDLE : S_HI;
          end
        end
        S_HI: begin
          if (w_adv) begin
            if (w_mi && !in_valid) begin
              r_hold  <= r_word[WIDTH-1:IW];
              r_state <= S_IMMW;
            end else begin
              if (w_pass) begin
                r_out_valid <= 1'b1;
                r_beat      <= w_beat;
              end
              // A MOVE-imm with its successor word already present completes now, so that word is never lost.
              if (in_valid) begin
                r_word  <= long_instr;
                r_state <= (w_mi || start_hi) ? S_HI : S_LO;
              end else begin
                r_state <= S_IDLE;
              end
            end
          end
        end
        S_IMMW: begin
          if (w_adv && in_valid) begin
            if (w_pass) begin
              r_out_valid <= 1'b1;
              r_beat      <= w_beat;
            end
            r_word  <= long_instr;
            r_state <= S_HI;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign alu_en    = r_beat.alu_en;
  assign opcode    = r_beat.opcode;
  assign mem_en    = r_beat.mem_en;
  assign wren      = r_beat.wren;
  assign move_en   = r_beat.move_en;
  assign mode      = r_beat.mode;
  assign immediate = r_beat.immediate;
  assign op1       = r_beat.op1;
  assign op2       = r_beat.op2;
  assign suffix    = r_beat.suffix;
  assign illegal   = r_beat.illegal;

endmodule
